// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM driving datapath mux selects and
// enables, with a req/ack handshake toward a unified instruction/data memory.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset; everything off, fetch next
// FETCH     | read instruction at PC, compute PC+4, load IR/PC on ack
// DECODE    | compute branch target into ALUOut, dispatch on opcode
// MEMADR    | base + sign-extended offset for lw/sw
// MEMRD     | load data read at ALUOut
// MEMWB     | write loaded data to rt
// MEMWR     | store reg B at ALUOut (final state of sw)
// RTYPE_EX  | ALU on A, B with funct
// RTYPE_WB  | write ALUOut to rd
// BEQ       | compare A, B; load branch target when zero
// IMM_EX    | addi (sign-ext add) or ori (zero-ext or)
// IMM_WB    | write ALUOut to rt
// JUMP      | load jump target
// JAL       | load jump target and link PC+4 into $31
// ERR       | unsupported opcode; parked until reset

module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src_sel,
  output logic       alu_srca_sel,
  output logic [2:0] alu_srcb_sel,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [2:0] SRCB_REG    = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SIMM   = 3'b010;
  localparam logic [2:0] SRCB_SIMMSH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM   = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_IMM_EX   = 4'd10,
    S_IMM_WB   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_ERR      = 4'd14
  } state_t;

  state_t state, state_next;

  // Async clear means mem_req, a pure state decode, drops with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (mem_ack) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    state_next = S_MEMADR;
          OP_RTYPE:        state_next = S_RTYPE_EX;
          OP_BEQ:          state_next = S_BEQ;
          OP_ADDI, OP_ORI: state_next = S_IMM_EX;
          OP_J:            state_next = S_JUMP;
          OP_JAL:          state_next = S_JAL;
          default:         state_next = S_ERR;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ack) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    if (mem_ack) state_next = S_FETCH;
      S_RTYPE_EX: state_next = S_RTYPE_WB;
      S_RTYPE_WB: state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_IMM_EX:   state_next = S_IMM_WB;
      S_IMM_WB:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_JAL:      state_next = S_FETCH;
      S_ERR:      state_next = S_ERR;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_en        = 1'b0;
    pc_src_sel   = PC_ALU;
    alu_srca_sel = 1'b0;
    alu_srcb_sel = SRCB_REG;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    reg_dst_sel  = DST_RT;
    wb_sel       = WB_ALUOUT;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_srcb_sel = SRCB_FOUR;
        ir_write     = mem_ack;
        pc_en        = mem_ack;
      end
      S_DECODE: begin
        alu_srcb_sel = SRCB_SIMMSH;
      end
      S_MEMADR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = SRCB_SIMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_RT;
        wb_sel      = WB_MEM;
        instr_done  = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ack;
      end
      S_RTYPE_EX: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = SRCB_REG;
        alu_op       = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_RD;
        wb_sel      = WB_ALUOUT;
        instr_done  = 1'b1;
      end
      S_BEQ: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = SRCB_REG;
        alu_op       = ALU_SUB;
        pc_src_sel   = PC_ALUOUT;
        pc_en        = zero;
        instr_done   = 1'b1;
      end
      S_IMM_EX: begin
        alu_srca_sel = 1'b1;
        if (opcode == OP_ORI) begin
          alu_srcb_sel = SRCB_ZIMM;
          alu_op       = ALU_OR;
        end else begin
          alu_srcb_sel = SRCB_SIMM;
          alu_op       = ALU_ADD;
        end
      end
      S_IMM_WB: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_RT;
        wb_sel      = WB_ALUOUT;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pc_en      = 1'b1;
        pc_src_sel = PC_JUMP;
        instr_done = 1'b1;
      end
      // PC still holds PC+4 here, so the link value is taken before the update.
      S_JAL: begin
        pc_en       = 1'b1;
        pc_src_sel  = PC_JUMP;
        reg_write   = 1'b1;
        reg_dst_sel = DST_RA;
        wb_sel      = WB_PC;
        instr_done  = 1'b1;
      end
      S_ERR: begin
        illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks instruction sequences cycle by
// cycle and compares the full output vector against hand-built expectations.

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src_sel;
  logic       alu_srca_sel;
  logic [2:0] alu_srcb_sel;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] reg_dst_sel, wb_sel;
  logic       instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src_sel(pc_src_sel), .alu_srca_sel(alu_srca_sel),
    .alu_srcb_sel(alu_srcb_sel), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst_sel(reg_dst_sel), .wb_sel(wb_sel), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  logic [19:0] obs;
  assign obs = {mem_req, mem_write, iord, ir_write, pc_en, pc_src_sel, alu_srca_sel,
                alu_srcb_sel, alu_op, reg_write, reg_dst_sel, wb_sel, instr_done,
                illegal_op};

  // Field order: req wr iord irw pce pcs srca srcb aop rw rdst wb done ill
  function automatic logic [19:0] ev(input logic req, wr, io, irw, pce,
                                     input logic [1:0] pcs, input logic sa,
                                     input logic [2:0] sb, input logic [1:0] aop,
                                     input logic rw, input logic [1:0] rd, wb,
                                     input logic done, ill);
    return {req, wr, io, irw, pce, pcs, sa, sb, aop, rw, rd, wb, done, ill};
  endfunction

  logic [19:0] E_OFF, E_FETCH_W, E_FETCH_A, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB;
  logic [19:0] E_MEMWR_W, E_MEMWR_A, E_RT_EX, E_RT_WB, E_BEQ_T, E_BEQ_N;
  logic [19:0] E_ADDI_EX, E_ORI_EX, E_IMM_WB, E_JUMP, E_JAL, E_ERR;

  initial begin
    E_OFF     = ev(0,0,0,0,0,2'b00,0,3'b000,2'b00,0,2'b00,2'b00,0,0);
    E_FETCH_W = ev(1,0,0,0,0,2'b00,0,3'b001,2'b00,0,2'b00,2'b00,0,0);
    E_FETCH_A = ev(1,0,0,1,1,2'b00,0,3'b001,2'b00,0,2'b00,2'b00,0,0);
    E_DECODE  = ev(0,0,0,0,0,2'b00,0,3'b011,2'b00,0,2'b00,2'b00,0,0);
    E_MEMADR  = ev(0,0,0,0,0,2'b00,1,3'b010,2'b00,0,2'b00,2'b00,0,0);
    E_MEMRD   = ev(1,0,1,0,0,2'b00,0,3'b000,2'b00,0,2'b00,2'b00,0,0);
    E_MEMWB   = ev(0,0,0,0,0,2'b00,0,3'b000,2'b00,1,2'b00,2'b01,1,0);
    E_MEMWR_W = ev(1,1,1,0,0,2'b00,0,3'b000,2'b00,0,2'b00,2'b00,0,0);
    E_MEMWR_A = ev(1,1,1,0,0,2'b00,0,3'b000,2'b00,0,2'b00,2'b00,1,0);
    E_RT_EX   = ev(0,0,0,0,0,2'b00,1,3'b000,2'b10,0,2'b00,2'b00,0,0);
    E_RT_WB   = ev(0,0,0,0,0,2'b00,0,3'b000,2'b00,1,2'b01,2'b00,1,0);
    E_BEQ_T   = ev(0,0,0,0,1,2'b01,1,3'b000,2'b01,0,2'b00,2'b00,1,0);
    E_BEQ_N   = ev(0,0,0,0,0,2'b01,1,3'b000,2'b01,0,2'b00,2'b00,1,0);
    E_ADDI_EX = ev(0,0,0,0,0,2'b00,1,3'b010,2'b00,0,2'b00,2'b00,0,0);
    E_ORI_EX  = ev(0,0,0,0,0,2'b00,1,3'b100,2'b11,0,2'b00,2'b00,0,0);
    E_IMM_WB  = ev(0,0,0,0,0,2'b00,0,3'b000,2'b00,1,2'b00,2'b00,1,0);
    E_JUMP    = ev(0,0,0,0,1,2'b10,0,3'b000,2'b00,0,2'b00,2'b00,1,0);
    E_JAL     = ev(0,0,0,0,1,2'b10,0,3'b000,2'b00,1,2'b10,2'b10,1,0);
    E_ERR     = ev(0,0,0,0,0,2'b00,0,3'b000,2'b00,0,2'b00,2'b00,0,1);
  end

  task automatic check(input string tag, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, apply inputs, let them settle, compare.
  task automatic cyc(input string tag, input logic ack, input logic z,
                     input logic [5:0] op, input logic [19:0] exp);
    @(posedge clk);
    #1;
    mem_ack = ack;
    zero    = z;
    opcode  = op;
    #1;
    check(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_ack = 1'b1;
    #1;
    check("reset_low", E_OFF);
    rst_n = 1'b1;
    #1;
    check("idle", E_OFF);

    // lw: fetch acked after two waits, data acked immediately
    cyc("lw_fetch_w0", 0, 0, 6'h23, E_FETCH_W);
    cyc("lw_fetch_w1", 0, 0, 6'h23, E_FETCH_W);
    cyc("lw_fetch_ack", 1, 0, 6'h23, E_FETCH_A);
    cyc("lw_decode", 0, 0, 6'h23, E_DECODE);
    cyc("lw_memadr", 0, 0, 6'h23, E_MEMADR);
    cyc("lw_memrd", 1, 0, 6'h23, E_MEMRD);
    cyc("lw_memwb", 0, 0, 6'h23, E_MEMWB);

    // beq taken then not taken; stray ack in DECODE must be ignored
    cyc("beq1_fetch", 1, 0, 6'h04, E_FETCH_A);
    cyc("beq1_decode", 1, 0, 6'h04, E_DECODE);
    cyc("beq1_taken", 0, 1, 6'h04, E_BEQ_T);
    cyc("beq2_fetch", 1, 0, 6'h04, E_FETCH_A);
    cyc("beq2_decode", 0, 0, 6'h04, E_DECODE);
    cyc("beq2_not_taken", 0, 0, 6'h04, E_BEQ_N);

    cyc("jal_fetch", 1, 0, 6'h03, E_FETCH_A);
    cyc("jal_decode", 0, 0, 6'h03, E_DECODE);
    cyc("jal_exec", 1, 0, 6'h03, E_JAL);

    cyc("addi_fetch", 1, 0, 6'h08, E_FETCH_A);
    cyc("addi_decode", 0, 0, 6'h08, E_DECODE);
    cyc("addi_ex", 0, 0, 6'h08, E_ADDI_EX);
    cyc("addi_wb", 0, 0, 6'h08, E_IMM_WB);
    cyc("ori_fetch", 1, 0, 6'h0D, E_FETCH_A);
    cyc("ori_decode", 0, 0, 6'h0D, E_DECODE);
    cyc("ori_ex", 0, 0, 6'h0D, E_ORI_EX);
    cyc("ori_wb", 0, 0, 6'h0D, E_IMM_WB);

    cyc("rtype_fetch", 1, 0, 6'h00, E_FETCH_A);
    cyc("rtype_decode", 1, 0, 6'h00, E_DECODE);
    cyc("rtype_ex", 1, 1, 6'h00, E_RT_EX);
    cyc("rtype_wb", 0, 0, 6'h00, E_RT_WB);

    cyc("j_fetch", 1, 0, 6'h02, E_FETCH_A);
    cyc("j_decode", 0, 0, 6'h02, E_DECODE);
    cyc("j_exec", 0, 0, 6'h02, E_JUMP);

    // sw with zero-wait store
    cyc("sw1_fetch", 1, 0, 6'h2B, E_FETCH_A);
    cyc("sw1_decode", 0, 0, 6'h2B, E_DECODE);
    cyc("sw1_memadr", 0, 0, 6'h2B, E_MEMADR);
    cyc("sw1_memwr_ack", 1, 0, 6'h2B, E_MEMWR_A);

    // sw stalled in MEMWR, then reset mid-cycle
    cyc("sw2_fetch", 1, 0, 6'h2B, E_FETCH_A);
    cyc("sw2_decode", 0, 0, 6'h2B, E_DECODE);
    cyc("sw2_memadr", 0, 0, 6'h2B, E_MEMADR);
    for (int i = 0; i < 4; i++) cyc("sw2_memwr_wait", 0, 0, 6'h2B, E_MEMWR_W);
    #2;
    rst_n = 1'b0;
    #1;
    check("sw2_async_reset", E_OFF);
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    #1;
    check("sw2_reset_hold", E_OFF);
    rst_n = 1'b1;
    #1;
    check("sw2_idle", E_OFF);
    cyc("sw2_refetch", 0, 0, 6'h3F, E_FETCH_W);

    // illegal opcode parks in ERR regardless of memory activity
    cyc("ill_fetch", 1, 0, 6'h3F, E_FETCH_A);
    cyc("ill_decode", 0, 0, 6'h3F, E_DECODE);
    for (int i = 0; i < 22; i++) cyc("ill_err", logic'(i[0]), logic'(i[1]), 6'h3F, E_ERR);
    #2;
    rst_n = 1'b0;
    #1;
    check("ill_async_reset", E_OFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ill_idle", E_OFF);
    cyc("ill_refetch", 0, 0, 6'h00, E_FETCH_W);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control unit. It is the Moore FSM that produces every select code consumed by the datapath muxes (2-, 3- and 5-input), plus the PC, IR, register-file and memory enables. It sits beside the datapath. It sequences fetch, decode, execute, memory and writeback, and it stalls on a req/ack handshake with the unified instruction/data memory.

Parameters:
None. Opcode and state encodings are fixed by this spec.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]; stable from DECODE until the instruction completes
zero  input  1  ALU zero flag, same cycle
mem_ack  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request, held until mem_ack
mem_write  output  1  access is a write (valid with mem_req)
iord  output  1  memory address select: 0 PC, 1 ALUOut
ir_write  output  1  load IR
pc_en  output  1  PC load enable (already combined with the branch condition)
pc_src_sel  output  2  00 ALU result, 01 ALUOut, 10 jump target
alu_srca_sel  output  1  0 PC, 1 reg A
alu_srcb_sel  output  3  000 reg B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm
alu_op  output  2  00 add, 01 sub, 10 use funct, 11 or
reg_write  output  1  register-file write enable
reg_dst_sel  output  2  00 rt, 01 rd, 10 $31
wb_sel  output  2  00 ALUOut, 01 memory data, 10 PC (link)
instr_done  output  1  one-cycle pulse in the final state of each instruction
illegal_op  output  1  sticky unsupported-opcode flag

Behaviour:
- Rising-edge state register; async clear to IDLE. All outputs are a combinational decode of the state (plus mem_ack, zero and opcode where stated).
- Unlisted outputs are 0.
- Reset values: every output is 0 while rst_n is low and while in IDLE.
- Reset mid-operation: the FSM enters IDLE immediately and mem_req drops asynchronously. No pending access is completed.
- IDLE: next state is FETCH unconditionally.
- FETCH: mem_req=1, iord=0, alu_srca=0, alu_srcb=001, alu_op=00, pc_src=00.
  - ir_write=pc_en=mem_ack.
  - Stay in FETCH while mem_ack=0. Go to DECODE on mem_ack=1.
- DECODE: alu_srca=0, alu_srcb=011, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x23 or 0x2B: MEMADR
  - 0x00: RTYPE_EX
  - 0x04: BEQ
  - 0x08 or 0x0D: IMM_EX
  - 0x02: JUMP
  - 0x03: JAL
  - any other: ERR
- MEMADR: alu_srca=1, alu_srcb=010, alu_op=00. Go to MEMRD if opcode=0x23, else MEMWR.
- MEMRD: mem_req=1, iord=1. Wait for mem_ack, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, wb_sel=01, instr_done=1. Go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Wait for mem_ack; on the ack cycle instr_done=1, then go to FETCH.
- RTYPE_EX: alu_srca=1, alu_srcb=000, alu_op=10. Go to RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=01, wb_sel=00, instr_done=1. Go to FETCH.
- BEQ: alu_srca=1, alu_srcb=000, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. Go to FETCH.
- IMM_EX: alu_srca=1.
  - Opcode 0x08: alu_srcb=010, alu_op=00.
  - Opcode 0x0D: alu_srcb=100, alu_op=11.
  - Go to IMM_WB.
- IMM_WB: reg_write=1, reg_dst=00, wb_sel=00, instr_done=1. Go to FETCH.
- JUMP: pc_en=1, pc_src=10, instr_done=1. Go to FETCH.
- JAL: pc_en=1, pc_src=10, reg_write=1, reg_dst=10, wb_sel=10, instr_done=1. Go to FETCH.
  - The register file samples the pre-update PC, which is PC+4 after fetch.
- ERR: illegal_op=1, all enables 0. Stay in ERR until reset.
- Cycle counts with zero-wait memory (ack in the first request cycle):
  - lw 5
  - sw 4
  - R-type, addi, ori 4
  - beq, j, jal 3
- Each wait cycle adds one cycle in FETCH, MEMRD or MEMWR. Outputs hold steady through waits; mem_req never deasserts before ack.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset, then lw (0x23), fetch ack after 2 wait cycles, data ack immediate:
  - IDLE→FETCH×3→DECODE→MEMADR→MEMRD→MEMWB.
  - pc_en and ir_write only on the ack cycle.
  - MEMWB: reg_write=1, wb_sel=01, reg_dst=00, instr_done=1.
- beq (0x04) run twice, zero=1 then zero=0:
  - BEQ state: pc_src=01, alu_op=01.
  - pc_en=1 on the first pass, pc_en=0 on the second.
  - 3 cycles each.
- jal (0x03): JAL state drives pc_en=1, pc_src=10, reg_write=1, reg_dst=10, wb_sel=10. Next cycle is FETCH.
- addi (0x08) then ori (0x0D): IMM_EX shows alu_srcb=010/alu_op=00, then alu_srcb=100/alu_op=11. IMM_WB shows reg_dst=00, wb_sel=00.
- Opcode 0x3F:
  - DECODE→ERR.
  - illegal_op=1 and all enables 0 for 20+ cycles with mem_ack toggling.
  - Assert rst_n=0: illegal_op=0 immediately.
- sw (0x2B) held in MEMWR with mem_ack=0:
  - mem_req=mem_write=iord=1 stable.
  - Drop rst_n mid-cycle: mem_req falls asynchronously.
  - Release reset: IDLE then FETCH.
